// File: rtl/shift_ex_stage_pkg.sv
// Shared definitions for the shift execute stage: R-type funct codes, buffer
// state encoding and the funct decoder used to steer the shifter.
package shift_ex_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic sll;
    logic srl;
    logic sra;
    logic use_rs;
    logic err;
  } shift_dec_t;

  function automatic shift_dec_t decode_funct(input logic [5:0] funct);
    shift_dec_t dec;
    dec = '0;
    unique case (funct)
      FUNCT_SLL:  dec.sll = 1'b1;
      FUNCT_SRL:  dec.srl = 1'b1;
      FUNCT_SRA:  dec.sra = 1'b1;
      FUNCT_SLLV: begin dec.sll = 1'b1; dec.use_rs = 1'b1; end
      FUNCT_SRLV: begin dec.srl = 1'b1; dec.use_rs = 1'b1; end
      FUNCT_SRAV: begin dec.sra = 1'b1; dec.use_rs = 1'b1; end
      default:    dec.err = 1'b1;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/shift_ex_stage_shift32.sv
// Combinational 32-bit shifter; at most one of sll/srl/sra is asserted and the
// output is zero when none is. Clock/reset pins exist for interface compatibility only.
module shift32
  import shift_ex_stage_pkg::*;
(
  input  logic            m_clock,
  input  logic            p_reset,
  input  logic [XLEN-1:0] din,
  input  logic [4:0]      amt,
  input  logic            sll,
  input  logic            srl,
  input  logic            sra,
  output logic [XLEN-1:0] dout
);

  logic w_unused_pins;
  assign w_unused_pins = m_clock ^ p_reset;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    dout = '0;
    if (sll)      dout = din << amt;
    else if (srl) dout = din >> amt;
    else if (sra) dout = $signed(din) >>> amt;
  end

endmodule

// File: rtl/shift_ex_stage.sv
// Execute-stage front end for shifts: decodes funct, selects the amount, shifts,
// and feeds a 2-entry elastic buffer (output reg + skid reg) towards MEM/WB.
module shift_ex_stage
  import shift_ex_stage_pkg::*;
#(
  parameter int RDW = 5
) (
  input  logic            m_clock,
  input  logic            p_reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      in_funct,
  input  logic [4:0]      in_shamt,
  input  logic [XLEN-1:0] in_rs,
  input  logic [XLEN-1:0] in_rt,
  input  logic [RDW-1:0]  in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [RDW-1:0]  out_rd,
  output logic            out_err
);

  buf_state_e r_state;
  buf_state_e w_state_nxt;

  shift_dec_t      w_dec;
  logic [4:0]      w_amt;
  logic [XLEN-1:0] w_shifted;
  logic            w_unused_rs;
  logic            w_accept;
  logic            w_drain;
  logic            w_load_out;
  logic            w_load_skid;
  logic            w_skid_to_out;

  logic [XLEN-1:0] r_out_result;
  logic [RDW-1:0]  r_out_rd;
  logic            r_out_err;
  logic [XLEN-1:0] r_skid_result;
  logic [RDW-1:0]  r_skid_rd;
  logic            r_skid_err;

  assign w_dec       = decode_funct(in_funct);
  assign w_amt       = w_dec.use_rs ? in_rs[4:0] : in_shamt;
  assign w_unused_rs = ^in_rs[XLEN-1:5];

  shift32 u_shift32 (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .din     (in_rt),
    .amt     (w_amt),
    .sll     (w_dec.sll),
    .srl     (w_dec.srl),
    .sra     (w_dec.sra),
    .dout    (w_shifted)
  );

  // Handshake flags depend on registered state only: no in_ready <- out_ready path.
  assign in_ready  = (r_state != ST_TWO);
  assign out_valid = (r_state != ST_EMPTY);
  assign w_accept  = in_valid & in_ready;
  assign w_drain   = out_valid & out_ready;

  // NOTE: sequential state uses non-blocking (<=) so all registers update together at the edge.
  always_ff @(posedge m_clock) begin
    if (!p_reset) r_state <= ST_EMPTY;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_load_out    = 1'b0;
    w_load_skid   = 1'b0;
    w_skid_to_out = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_load_out  = 1'b1;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_drain) begin
            w_load_out = 1'b1;
          end else if (w_accept) begin
            w_load_skid = 1'b1;
            w_state_nxt = ST_TWO;
          end else if (w_drain) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_drain) begin
            w_skid_to_out = 1'b1;
            w_state_nxt   = ST_ONE;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge m_clock) begin
    if (!p_reset) begin
      r_out_result <= '0;
      r_out_rd     <= '0;
      r_out_err    <= 1'b0;
    end else if (w_load_out) begin
      r_out_result <= w_shifted;
      r_out_rd     <= in_rd;
      r_out_err    <= w_dec.err;
    end else if (w_skid_to_out) begin
      r_out_result <= r_skid_result;
      r_out_rd     <= r_skid_rd;
      r_out_err    <= r_skid_err;
    end
  end

  // NOTE: skid data is not reset; it is only ever observed after a load guarded by state.
  always_ff @(posedge m_clock) begin
    if (w_load_skid) begin
      r_skid_result <= w_shifted;
      r_skid_rd     <= in_rd;
      r_skid_err    <= w_dec.err;
    end
  end

  assign out_result = r_out_result;
  assign out_rd     = r_out_rd;
  assign out_err    = r_out_err;

endmodule
